// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
package mux_pkg;

  // Encodings of the mode input.
  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Low bit of channel idx inside a packed bus of width-bit channels.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter built as a double-width masked priority encoder.
//
// The lower copy of the request vector keeps only the channels above
// last_grant. The upper copy is unmasked. The lowest set bit of the
// concatenation is therefore the first requester after last_grant, wrapping
// round to channel 0.
module rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_W-1:0]      last_grant,
  input  logic                  enable,
  output logic [NUM_INPUTS-1:0] grant_onehot,
  output logic [SEL_W-1:0]      grant_idx,
  output logic                  any_req
);

  logic [NUM_INPUTS-1:0]   mask;
  logic [2*NUM_INPUTS-1:0] req_dbl;
  logic                    found;

  // Build the mask that keeps only the channels strictly above last_grant.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      mask[i] = (i > int'(last_grant));
    end
  end

  assign req_dbl = {req, req & mask};
  assign any_req = |req;

  // Priority-encode the lowest set bit and fold it back into channel range.
  // NOTE: every output of a combinational block gets a default before any branch, so no path can infer a latch.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < 2 * NUM_INPUTS; i++) begin
      if (!found && req_dbl[i]) begin
        grant_idx = SEL_W'(i % NUM_INPUTS);
        found     = 1'b1;
      end
    end
  end

  // The one-hot grant is only issued when the arbiter is in use and something is requesting.
  always_comb begin
    grant_onehot = '0;
    if (enable && any_req) begin
      grant_onehot = NUM_INPUTS'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// The channel is chosen by an external select (static mode) or by a fair
// round-robin arbiter (round-robin mode).
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_W     = 8,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             select,
  input  logic [NUM_INPUTS*DATA_W-1:0] inp_data,
  input  logic [NUM_INPUTS-1:0]        inp_valid,
  output logic [NUM_INPUTS-1:0]        inp_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_W-1:0]             out_sel
);

  logic [SEL_W-1:0]      last_grant;
  logic [SEL_W-1:0]      rr_idx;
  logic [SEL_W-1:0]      grant_idx;
  logic [NUM_INPUTS-1:0] rr_onehot;
  logic                  any_req;
  logic                  accept;
  logic                  xfer;
  logic [DATA_W-1:0]     tree [SEL_W+1][NUM_INPUTS];
  logic [DATA_W-1:0]     sel_data;

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_W      (SEL_W)
  ) u_arb (
    .req          (inp_valid),
    .last_grant   (last_grant),
    .enable       (mode == MODE_RR),
    .grant_onehot (rr_onehot),
    .grant_idx    (rr_idx),
    .any_req      (any_req)
  );

  // The output register can take a new word when it is empty or being drained this cycle.
  assign accept = !out_valid || out_ready;

  // Choose the granted channel and raise its ready. At most one ready bit is high.
  always_comb begin
    grant_idx = select;
    inp_ready = '0;
    if (mode == MODE_RR) begin
      grant_idx = rr_idx;
      if (accept) inp_ready = rr_onehot;
    end else if (accept) begin
      inp_ready = NUM_INPUTS'(1) << select;
    end
  end

  assign xfer = |(inp_valid & inp_ready);

  // Binary tree of 2:1 selections. Address bit l steers level l.
  always_comb begin
    for (int l = 0; l <= SEL_W; l++) begin
      for (int j = 0; j < NUM_INPUTS; j++) begin
        tree[l][j] = '0;
      end
    end
    for (int j = 0; j < NUM_INPUTS; j++) begin
      tree[0][j] = inp_data[slice_lo(j, DATA_W) +: DATA_W];
    end
    for (int l = 0; l < SEL_W; l++) begin
      for (int j = 0; j < (NUM_INPUTS >> (l + 1)); j++) begin
        tree[l+1][j] = grant_idx[l] ? tree[l][2*j+1] : tree[l][2*j];
      end
    end
  end

  assign sel_data = tree[SEL_W][0];

  // Output register and round-robin pointer. The pointer only moves on round-robin transfers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SEL_W'(NUM_INPUTS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
      if (mode == MODE_RR) last_grant <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N:1 stream multiplexer with a registered output and valid/ready handshakes on every input and on the output.
- Generalises the fixed 4:1 single-bit mux to NUM_INPUTS channels of DATA_W bits.
- Two modes:
  - Static: an external select picks the channel.
  - Round-robin: the block arbitrates fairly among the valid channels.
- Sits between several producer blocks and one shared consumer, for example a shared ALU result bus.

Parameters:
NUM_INPUTS, 4, number of input channels; power of two, 2..16
DATA_W, 8, width of each channel's data in bits
SEL_W, $clog2(NUM_INPUTS), select and grant index width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = static select, 1 = round-robin
select  input  SEL_W  channel index used in static mode
inp_data  input  NUM_INPUTS*DATA_W  packed channel data; channel i at [i*DATA_W +: DATA_W]
inp_valid  input  NUM_INPUTS  per-channel valid
inp_ready  output  NUM_INPUTS  per-channel ready; at most one bit high
out_data  output  DATA_W  registered output data
out_valid  output  1  registered output valid
out_ready  input  1  consumer ready
out_sel  output  SEL_W  index of the channel that produced out_data

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=NUM_INPUTS-1, so channel 0 has first priority after reset.
- Reset mid-transfer discards the held word. No transfer completes in the cycle rst_n deasserts.
- accept = !out_valid || out_ready. This is a single-register pipeline stage and allows full throughput of one word per cycle.
- Static mode (mode=0):
  - grant index = select.
  - inp_ready[select] = accept; all other inp_ready bits are 0.
  - inp_ready does not depend on inp_valid.
- Round-robin mode (mode=1):
  - grant = first channel with inp_valid set, searching from last_grant+1 upward and wrapping at NUM_INPUTS-1 to 0.
  - inp_ready[grant] = accept only when some inp_valid is set; otherwise inp_ready is all zero.
- Transfer on channel g: inp_valid[g] && inp_ready[g].
  - Next edge: out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - In round-robin mode only, last_grant <= g.
- No transfer while out_ready=1: out_valid <= 0 on the next edge. out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready):
  - out_data, out_sel and out_valid hold.
  - All inp_ready bits are 0.
  - Changes on select or mode do not disturb the held word.
- Latency: one cycle from input transfer to out_valid.
- Mode or select change: sampled combinationally every cycle and takes effect on the next arbitration. last_grant is not modified by static-mode transfers.
- Select wrap: select is always in range because NUM_INPUTS is a power of two.
- Contract on producers: inp_valid must not depend combinationally on inp_ready. Once asserted, inp_valid and the data hold until transfer (checked by bench assertions, not by RTL).
- Invariant: $onehot0(inp_ready) in every cycle.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_STATIC=1'b0 and MODE_RR=1'b1.
  - A function for the packed-slice index.
- One sub-module, rr_arbiter:
  - Parameter NUM_INPUTS.
  - Inputs: req, last_grant, enable.
  - Outputs: grant_onehot, grant_idx, any_req.
  - Implemented as a double-width masked priority encoder.
- Data selection is an SEL_W-level binary tree of 2:1 selections indexed by grant index, inline in the top module.

Test Plan:
- Reset/static: assert rst_n low mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately. Release, then mode=0, select=2, inp_valid=4'b0100, inp_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_sel=2, inp_ready=4'b0100.
- Static ignore: mode=0, select=1, inp_valid=4'b1101 (ch1 idle) -> inp_ready=4'b0010, no transfer, out_valid stays 0.
- Round-robin fairness: mode=1, all four valid continuously, out_ready=1, ch i data=8'h10+i -> out_sel sequence 0,1,2,3,0,1 and out_data 8'h10,11,12,13,10,11, one word per cycle.
- Sparse RR wrap: last grant=2, inp_valid=4'b0011 -> grant ch0, then ch1, then ch0. Channel 3 is skipped without a bubble.
- Backpressure: RR transfer lands out_data=8'h11, then out_ready=0 for 3 cycles while select and mode toggle -> out_data=8'h11, out_sel=1, out_valid=1 held, inp_ready=0. When out_ready returns to 1, the next word follows the cycle after.
- Mode switch: in RR after grant ch3, switch to mode=0, select=3 for 2 words, then back to mode=1 -> the first RR grant resumes at ch0 (last_grant unchanged by static transfers).
